// File: rtl/acc_core_pkg.sv
// rtl/acc_core_pkg.sv - shared states, opcodes, field positions and write classes for the accumulator sequencer
package acc_core_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} stateT;
  typedef enum logic [1:0] {WR_NONE, WR_ACC, WR_REG, WR_MEM} wrClassT;

  // Instruction fields: Type=1 selects the I format
  localparam int TYPE_BIT = 8;
  localparam int ROP_HI = 7, ROP_LO = 4, REG_HI = 3, REG_LO = 0;
  localparam int IOP_HI = 7, IOP_LO = 5, IMM_HI = 4, IMM_LO = 0;

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_LOAD = 4'd1,  OP_MVTO = 4'd3,  OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5,  OP_OR   = 4'd6,  OP_XOR  = 4'd7,  OP_STR  = 4'd8;
  localparam logic [3:0] OP_MVFR = 4'd9,  OP_SLT  = 4'd10, OP_BTRU = 4'd11, OP_SHL  = 4'd12;
  localparam logic [3:0] OP_NOT  = 4'd13, OP_HALT = 4'd15;

  localparam logic [2:0] OP_ADDI = 3'd1, OP_SUBI = 3'd2, OP_B = 3'd3, OP_LSLI = 3'd4, OP_LSRI = 3'd5;

  // LOAD lands in the accumulator, so it is ACC; only STR targets memory
  function automatic wrClassT writeClass(input logic isI, input logic [3:0] op);
    wrClassT wc;
    wc = WR_NONE;
    if (!isI) begin
      case (op)
        OP_ADD, OP_LOAD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_MVFR, OP_SLT, OP_SHL, OP_NOT: wc = WR_ACC;
        OP_MVTO:                         wc = WR_REG;
        OP_STR:                          wc = WR_MEM;
        default:                         wc = WR_NONE;
      endcase
    end else begin
      case (op[2:0])
        OP_ADDI, OP_SUBI, OP_LSLI, OP_LSRI: wc = WR_ACC;
        default:                            wc = WR_NONE;
      endcase
    end
    return wc;
  endfunction

endpackage

// File: rtl/acc_decode.sv
// rtl/acc_decode.sv - combinational instruction-register decode for the accumulator sequencer
module acc_decode
  import acc_core_pkg::*;
(
  input  logic [8:0] ir,
  output logic       aluType,
  output logic [3:0] rOp,
  output logic [2:0] iOp,
  output logic [4:0] imm,
  output logic       accWrite,
  output logic       regWrite,
  output logic       isBranch,
  output logic       isMem,
  output logic       isStore,
  output logic       isHalt,
  output logic       illegal,
  output logic [4:0] lutAddr
);

  wrClassT wc;

  always_comb begin
    aluType  = ir[TYPE_BIT];
    rOp      = ir[ROP_HI:ROP_LO];
    iOp      = ir[IOP_HI:IOP_LO];
    imm      = ir[IMM_HI:IMM_LO];
    wc       = writeClass(aluType, aluType ? {1'b0, iOp} : rOp);
    accWrite = (wc == WR_ACC);
    regWrite = (wc == WR_REG);
    isBranch = aluType ? (iOp == OP_B) : (rOp == OP_BTRU);
    isMem    = !aluType && (rOp == OP_LOAD || rOp == OP_STR);
    isStore  = !aluType && (rOp == OP_STR);
    isHalt   = !aluType && (rOp == OP_HALT);
    illegal  = aluType ? (iOp == 3'd0 || iOp == 3'd6 || iOp == 3'd7)
                       : (rOp == 4'd2 || rOp == 4'd14);
    lutAddr  = 5'd0;
    if (isBranch) lutAddr = aluType ? imm : {1'b0, ir[REG_HI:REG_LO]};
  end

endmodule

// File: rtl/acc_core_ctrl.sv
// rtl/acc_core_ctrl.sv - multi-cycle fetch/decode/exec/mem/writeback sequencer for the accumulator ALU
module acc_core_ctrl
  import acc_core_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int START_PC = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  output logic            InstReq,
  output logic [PC_W-1:0] InstAddr,
  input  logic            InstAck,
  input  logic [8:0]      InstData,
  output logic            AluType,
  output logic [3:0]      AluROp,
  output logic [2:0]      AluIOp,
  output logic [4:0]      AluImm,
  input  logic            AluBranch,
  output logic [3:0]      RegSel,
  output logic            OperandSel,
  output logic            MemReq,
  output logic            MemWe,
  input  logic            MemAck,
  output logic [4:0]      LutAddr,
  input  logic [PC_W-1:0] LutTarget,
  output logic            AccWe,
  output logic            RegWe,
  output logic            Busy,
  output logic            Done,
  output logic            IllegalOp
);

  stateT           state;
  logic [PC_W-1:0] pc;
  logic [8:0]      ir;
  logic            taken;

  logic       dAluType, dAccWrite, dRegWrite, dBranch, dMem, dStore, dHalt, dIllegal;
  logic [3:0] dROp;
  logic [2:0] dIOp;
  logic [4:0] dImm, dLutAddr;

  acc_decode uDecode (
    .ir       (ir),
    .aluType  (dAluType),
    .rOp      (dROp),
    .iOp      (dIOp),
    .imm      (dImm),
    .accWrite (dAccWrite),
    .regWrite (dRegWrite),
    .isBranch (dBranch),
    .isMem    (dMem),
    .isStore  (dStore),
    .isHalt   (dHalt),
    .illegal  (dIllegal),
    .lutAddr  (dLutAddr)
  );

  assign InstAddr = pc;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      pc         <= PC_W'(START_PC);
      ir         <= '0;
      taken      <= 1'b0;
      InstReq    <= 1'b0;
      MemReq     <= 1'b0;
      MemWe      <= 1'b0;
      OperandSel <= 1'b0;
      AccWe      <= 1'b0;
      RegWe      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      IllegalOp  <= 1'b0;
      AluType    <= 1'b0;
      AluROp     <= '0;
      AluIOp     <= '0;
      AluImm     <= '0;
      RegSel     <= '0;
      LutAddr    <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (Start) begin
            state   <= FETCH;
            pc      <= PC_W'(START_PC);
            InstReq <= 1'b1;
            Busy    <= 1'b1;
            Done    <= 1'b0;
          end
        end
        FETCH: begin
          if (InstAck) begin
            ir      <= InstData;
            InstReq <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          AluType   <= dAluType;
          AluROp    <= dROp;
          AluIOp    <= dIOp;
          AluImm    <= dImm;
          RegSel    <= ir[REG_HI:REG_LO];
          LutAddr   <= dLutAddr;
          IllegalOp <= dIllegal;
          state     <= EXEC;
        end
        EXEC: begin
          // ALU controls have been stable a full cycle, so the branch flag is settled here
          IllegalOp <= 1'b0;
          taken     <= dBranch & AluBranch;
          if (dMem) begin
            state      <= MEM;
            MemReq     <= 1'b1;
            MemWe      <= dStore;
            OperandSel <= !dStore;
          end else if (dHalt) begin
            state <= HALT;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            state <= WB;
            AccWe <= dAccWrite;
            RegWe <= dRegWrite;
          end
        end
        MEM: begin
          if (MemAck) begin
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            AccWe  <= dAccWrite;
            state  <= WB;
          end
        end
        WB: begin
          AccWe      <= 1'b0;
          RegWe      <= 1'b0;
          OperandSel <= 1'b0;
          pc         <= taken ? LutTarget : pc + 1'b1;
          InstReq    <= 1'b1;
          state      <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_core_ctrl.sv
// tb/tb_acc_core_ctrl.sv - randomized self-checking bench for acc_core_ctrl against an instruction-level model
module tb_acc_core_ctrl;

  localparam int PC_W = 10;
  localparam int START_PC = 0;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            Start = 1'b0;
  logic            InstReq;
  logic [PC_W-1:0] InstAddr;
  logic            InstAck = 1'b0;
  logic [8:0]      InstData = '0;
  logic            AluType;
  logic [3:0]      AluROp;
  logic [2:0]      AluIOp;
  logic [4:0]      AluImm;
  logic            AluBranch = 1'b0;
  logic [3:0]      RegSel;
  logic            OperandSel;
  logic            MemReq;
  logic            MemWe;
  logic            MemAck = 1'b0;
  logic [4:0]      LutAddr;
  logic [PC_W-1:0] LutTarget = '0;
  logic            AccWe;
  logic            RegWe;
  logic            Busy;
  logic            Done;
  logic            IllegalOp;

  int total = 0;
  int bad = 0;

  acc_core_ctrl #(.PC_W(PC_W), .START_PC(START_PC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InstReq(InstReq), .InstAddr(InstAddr),
    .InstAck(InstAck), .InstData(InstData), .AluType(AluType), .AluROp(AluROp),
    .AluIOp(AluIOp), .AluImm(AluImm), .AluBranch(AluBranch), .RegSel(RegSel),
    .OperandSel(OperandSel), .MemReq(MemReq), .MemWe(MemWe), .MemAck(MemAck),
    .LutAddr(LutAddr), .LutTarget(LutTarget), .AccWe(AccWe), .RegWe(RegWe),
    .Busy(Busy), .Done(Done), .IllegalOp(IllegalOp)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int cycles, accCnt, regCnt, illCnt, memCyc, accCycle, ackCycle;
    bit memWeSeen, opSelSeen, halted, timeout;
    logic [PC_W-1:0] fetchAddr, nextAddr;
    logic [4:0] lut, imm;
    logic [3:0] rop, regSel;
    logic [2:0] iop;
    logic aluType;
  } obsT;

  typedef struct {
    bit acc, regw, ill, halt, mem, store, branch;
    logic [4:0] lut;
  } expT;

  // Instruction-level expectations taken straight from the opcode tables
  function automatic expT refModel(input logic [8:0] ins);
    expT e;
    int op;
    e.acc = 0; e.regw = 0; e.ill = 0; e.halt = 0; e.mem = 0; e.store = 0; e.branch = 0; e.lut = '0;
    if (ins[8] == 1'b0) begin
      op = int'(ins[7:4]);
      e.acc    = op inside {0, 1, 4, 5, 6, 7, 9, 10, 12, 13};
      e.regw   = (op == 3);
      e.ill    = op inside {2, 14};
      e.halt   = (op == 15);
      e.mem    = op inside {1, 8};
      e.store  = (op == 8);
      e.branch = (op == 11);
      if (e.branch) e.lut = {1'b0, ins[3:0]};
    end else begin
      op = int'(ins[7:5]);
      e.acc    = op inside {1, 2, 4, 5};
      e.ill    = op inside {0, 6, 7};
      e.branch = (op == 3);
      if (e.branch) e.lut = ins[4:0];
    end
    return e;
  endfunction

  task automatic doReset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic doStart();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Acts as instruction/data memory for one instruction, from FETCH entry to the next FETCH or HALT
  task automatic execInstr(input logic [8:0] ins, input logic br, input logic [PC_W-1:0] tgt,
                           input int instDly, input int memDly, input bit noise, output obsT o);
    int fetchWait;
    bit sawAck;
    fetchWait = 0; sawAck = 0;
    o.cycles = 0; o.accCnt = 0; o.regCnt = 0; o.illCnt = 0; o.memCyc = 0; o.accCycle = -1;
    o.ackCycle = -1; o.memWeSeen = 0; o.opSelSeen = 0; o.halted = 0; o.timeout = 1;
    o.fetchAddr = InstAddr; o.nextAddr = '0;
    AluBranch = br; LutTarget = tgt;
    for (int k = 0; k < 200; k++) begin
      if (Done) begin o.halted = 1; o.cycles = k; o.timeout = 0; break; end
      if (InstReq && sawAck) begin o.cycles = k; o.nextAddr = InstAddr; o.timeout = 0; break; end
      if (AccWe) begin o.accCnt++; o.accCycle = k; end
      if (RegWe) o.regCnt++;
      if (IllegalOp) o.illCnt++;
      if (MemReq) begin
        o.memCyc++;
        if (MemWe) o.memWeSeen = 1;
        if (OperandSel) o.opSelSeen = 1;
      end
      InstAck = 1'b0; MemAck = 1'b0;
      InstData = noise ? 9'($urandom) : 9'd0;
      if (InstReq) begin
        if (fetchWait == instDly) begin InstAck = 1'b1; InstData = ins; sawAck = 1; end
        else fetchWait++;
      end else if (noise) InstAck = 1'($urandom);
      if (MemReq) begin
        if (o.memCyc == memDly + 1) begin MemAck = 1'b1; o.ackCycle = k; end
      end else if (noise) MemAck = 1'($urandom);
      Start = noise && Busy && ($urandom % 4 == 0);
      @(negedge Clk);
    end
    Start = 1'b0; InstAck = 1'b0; MemAck = 1'b0;
    o.lut = LutAddr; o.imm = AluImm; o.rop = AluROp; o.iop = AluIOp;
    o.aluType = AluType; o.regSel = RegSel;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    total++;
    if ({InstReq, MemReq, MemWe, AccWe, RegWe, Done, IllegalOp, Busy, OperandSel} !== 9'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000000",
        {InstReq, MemReq, MemWe, AccWe, RegWe, Done, IllegalOp, Busy, OperandSel});
    end
    total++;
    if (InstAddr !== PC_W'(START_PC)) begin bad++; $display("FAIL reset_addr: got %0h want %0h", InstAddr, START_PC); end
    total++;
    if ({AluType, AluROp, AluIOp, AluImm, LutAddr, RegSel} !== '0) begin
      bad++; $display("FAIL reset_alu: got %0h want 0", {AluType, AluROp, AluIOp, AluImm, LutAddr, RegSel});
    end
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    total++;
    if ({InstReq, Busy} !== 2'b00) begin bad++; $display("FAIL idle_no_start: got %b want 00", {InstReq, Busy}); end
  endtask

  task automatic test_addi_halt();
    obsT o;
    doStart();
    total++;
    if ({InstReq, Busy, InstAddr} !== {2'b11, PC_W'(0)}) begin
      bad++; $display("FAIL start_fetch: got %b/%b/%0h want 1/1/0", InstReq, Busy, InstAddr);
    end
    execInstr({1'b1, 3'd1, 5'd5}, 1'b0, '0, 0, 0, 0, o);
    total++;
    if (o.accCnt != 1 || o.accCycle != 3 || o.cycles != 4) begin
      bad++; $display("FAIL addi_timing: got acc=%0d at %0d lat=%0d want 1 at 3 lat=4", o.accCnt, o.accCycle, o.cycles);
    end
    total++;
    if ({o.aluType, o.iop, o.imm} !== {1'b1, 3'd1, 5'd5}) begin
      bad++; $display("FAIL addi_ctrl: got %b/%0d/%0d want 1/1/5", o.aluType, o.iop, o.imm);
    end
    total++;
    if (o.fetchAddr !== 0 || o.nextAddr !== 1) begin
      bad++; $display("FAIL addi_addr: got %0h,%0h want 0,1", o.fetchAddr, o.nextAddr);
    end
    execInstr({1'b0, 4'd15, 4'd0}, 1'b0, '0, 0, 0, 0, o);
    total++;
    if (!o.halted || {Done, Busy, InstReq, MemReq} !== 4'b1000) begin
      bad++; $display("FAIL halt_state: got halted=%0d D/B/IR/MR=%b want 1 1000", o.halted, {Done, Busy, InstReq, MemReq});
    end
  endtask

  task automatic test_branch();
    obsT o;
    doStart();
    execInstr({1'b1, 3'd3, 5'd7}, 1'b1, PC_W'(10'h2A), 1, 0, 0, o);
    total++;
    if (o.lut !== 5'd7 || o.accCnt + o.regCnt != 0 || o.nextAddr !== PC_W'(10'h2A)) begin
      bad++; $display("FAIL b_taken: got lut=%0d wr=%0d next=%0h want 7 0 2a", o.lut, o.accCnt + o.regCnt, o.nextAddr);
    end
    execInstr({1'b0, 4'd11, 4'd3}, 1'b0, PC_W'(10'h155), 0, 0, 0, o);
    total++;
    if (o.lut !== 5'd3 || o.accCnt + o.regCnt != 0 || o.nextAddr !== PC_W'(10'h2B)) begin
      bad++; $display("FAIL btru_not_taken: got lut=%0d wr=%0d next=%0h want 3 0 2b", o.lut, o.accCnt + o.regCnt, o.nextAddr);
    end
  endtask

  task automatic test_mem();
    obsT o;
    execInstr({1'b0, 4'd1, 4'd2}, 1'b0, '0, 0, 3, 0, o);
    total++;
    if (o.memCyc != 4 || o.memWeSeen || !o.opSelSeen) begin
      bad++; $display("FAIL load_mem: got memCyc=%0d we=%0d opsel=%0d want 4 0 1", o.memCyc, o.memWeSeen, o.opSelSeen);
    end
    total++;
    if (o.accCnt != 1 || o.accCycle != o.ackCycle + 1 || o.regSel !== 4'd2 || o.nextAddr !== PC_W'(10'h2C)) begin
      bad++; $display("FAIL load_wb: got acc=%0d at %0d ack=%0d reg=%0d next=%0h want 1 at ack+1 reg 2 next 2c",
        o.accCnt, o.accCycle, o.ackCycle, o.regSel, o.nextAddr);
    end
    execInstr({1'b0, 4'd8, 4'd5}, 1'b0, '0, 0, 1, 0, o);
    total++;
    if (o.memCyc != 2 || !o.memWeSeen || o.opSelSeen || o.accCnt != 0 || o.nextAddr !== PC_W'(10'h2D)) begin
      bad++; $display("FAIL str: got memCyc=%0d we=%0d opsel=%0d acc=%0d next=%0h want 2 1 0 0 2d",
        o.memCyc, o.memWeSeen, o.opSelSeen, o.accCnt, o.nextAddr);
    end
  endtask

  task automatic test_illegal_wrap();
    obsT o;
    execInstr({1'b1, 3'd6, 5'd9}, 1'b1, '0, 0, 0, 0, o);
    total++;
    if (o.illCnt != 1 || o.accCnt + o.regCnt != 0 || o.nextAddr !== PC_W'(10'h2E)) begin
      bad++; $display("FAIL illegal_i6: got ill=%0d wr=%0d next=%0h want 1 0 2e", o.illCnt, o.accCnt + o.regCnt, o.nextAddr);
    end
    execInstr({1'b0, 4'd3, 4'd4}, 1'b0, '0, 0, 0, 0, o);
    total++;
    if (o.regCnt != 1 || o.accCnt != 0 || o.illCnt != 0) begin
      bad++; $display("FAIL mvto: got reg=%0d acc=%0d ill=%0d want 1 0 0", o.regCnt, o.accCnt, o.illCnt);
    end
    execInstr({1'b1, 3'd3, 5'd1}, 1'b1, PC_W'(1023), 0, 0, 0, o);
    execInstr({1'b0, 4'd0, 4'd1}, 1'b0, '0, 0, 0, 0, o);
    total++;
    if (o.fetchAddr !== PC_W'(1023) || o.nextAddr !== PC_W'(0) || o.accCnt != 1) begin
      bad++; $display("FAIL pc_wrap: got %0h->%0h acc=%0d want 3ff->0 acc=1", o.fetchAddr, o.nextAddr, o.accCnt);
    end
  endtask

  task automatic test_start_busy();
    obsT o;
    execInstr({1'b0, 4'd4, 4'd1}, 1'b0, '0, 0, 0, 0, o);
    InstAck = 1'b0;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    total++;
    if (InstAddr !== PC_W'(1) || {InstReq, Busy} !== 2'b11) begin
      bad++; $display("FAIL start_busy: got addr=%0h req/busy=%b want 1 11", InstAddr, {InstReq, Busy});
    end
    execInstr({1'b0, 4'd15, 4'd0}, 1'b0, '0, 0, 0, 0, o);
    total++;
    if (!o.halted || o.fetchAddr !== PC_W'(1)) begin
      bad++; $display("FAIL start_busy_halt: got halted=%0d addr=%0h want 1 1", o.halted, o.fetchAddr);
    end
  endtask

  task automatic test_random();
    obsT o;
    expT e;
    int modelPc, instDly, memDly, lat, nxt;
    logic br;
    logic [PC_W-1:0] tgt;
    logic [8:0] ins;
    doReset();
    doStart();
    modelPc = START_PC;
    for (int n = 0; n < 80; n++) begin
      ins = 9'($urandom);
      if (ins[8] == 1'b0 && ins[7:4] == 4'd15 && ($urandom % 3 != 0)) ins[7:4] = 4'd6;
      br = 1'($urandom);
      tgt = PC_W'($urandom);
      instDly = $urandom_range(0, 3);
      memDly = $urandom_range(0, 3);
      e = refModel(ins);
      execInstr(ins, br, tgt, instDly, memDly, 1, o);
      lat = instDly + 1 + (e.halt ? 2 : 3) + (e.mem ? memDly + 1 : 0);
      total++;
      if (o.timeout || o.fetchAddr !== PC_W'(modelPc) || o.cycles != lat || o.halted != e.halt) begin
        bad++; $display("FAIL rnd_flow[%0d] ins=%h: got to=%0d addr=%0h lat=%0d halt=%0d want 0 %0h %0d %0d",
          n, ins, o.timeout, o.fetchAddr, o.cycles, o.halted, modelPc, lat, e.halt);
      end
      total++;
      if (o.accCnt != int'(e.acc) || o.regCnt != int'(e.regw) || o.illCnt != int'(e.ill) ||
          (e.acc && o.accCycle != lat - 1)) begin
        bad++; $display("FAIL rnd_writes[%0d] ins=%h: got acc=%0d@%0d reg=%0d ill=%0d want %0d@%0d %0d %0d",
          n, ins, o.accCnt, o.accCycle, o.regCnt, o.illCnt, e.acc, lat - 1, e.regw, e.ill);
      end
      total++;
      if (o.memCyc != (e.mem ? memDly + 1 : 0) || o.memWeSeen != e.store || o.opSelSeen != (e.mem && !e.store)) begin
        bad++; $display("FAIL rnd_mem[%0d] ins=%h: got cyc=%0d we=%0d opsel=%0d want %0d %0d %0d",
          n, ins, o.memCyc, o.memWeSeen, o.opSelSeen, e.mem ? memDly + 1 : 0, e.store, e.mem && !e.store);
      end
      total++;
      if (o.lut !== e.lut || {o.aluType, o.rop, o.iop, o.imm, o.regSel} !==
          {ins[8], ins[7:4], ins[7:5], ins[4:0], ins[3:0]}) begin
        bad++; $display("FAIL rnd_ctrl[%0d] ins=%h: got lut=%0d type=%b rop=%0d iop=%0d imm=%0d reg=%0d want lut=%0d",
          n, ins, o.lut, o.aluType, o.rop, o.iop, o.imm, o.regSel, e.lut);
      end
      if (e.halt) begin
        doStart();
        modelPc = START_PC;
      end else begin
        nxt = (e.branch && br) ? int'(tgt) : (modelPc + 1) % (1 << PC_W);
        total++;
        if (o.nextAddr !== PC_W'(nxt)) begin
          bad++; $display("FAIL rnd_next[%0d] ins=%h br=%0d: got %0h want %0h", n, ins, br, o.nextAddr, nxt);
        end
        modelPc = nxt;
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    int accSeen;
    doReset();
    doStart();
    InstAck = 1'b1;
    InstData = {1'b0, 4'd1, 4'd2};
    @(negedge Clk);
    InstAck = 1'b0;
    for (int i = 0; i < 20 && !MemReq; i++) @(negedge Clk);
    total++;
    if (MemReq !== 1'b1) begin bad++; $display("FAIL mid_mem_reach: got MemReq=%b want 1", MemReq); end
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    total++;
    if ({MemReq, MemWe, Busy, AccWe, OperandSel} !== 5'b0 || InstAddr !== PC_W'(START_PC)) begin
      bad++; $display("FAIL mid_mem_reset: got req/we/busy/acc/opsel=%b addr=%0h want 00000 0",
        {MemReq, MemWe, Busy, AccWe, OperandSel}, InstAddr);
    end
    @(negedge Clk);
    Reset = 1'b0;
    MemAck = 1'b1;
    accSeen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (AccWe || RegWe) accSeen++;
    end
    MemAck = 1'b0;
    total++;
    if (accSeen != 0 || {InstReq, MemReq, Busy} !== 3'b000) begin
      bad++; $display("FAIL post_reset_idle: got writes=%0d req/mreq/busy=%b want 0 000", accSeen, {InstReq, MemReq, Busy});
    end
  endtask

  initial begin
    test_reset();
    test_addi_halt();
    test_branch();
    test_mem();
    test_illegal_wrap();
    test_start_busy();
    test_random();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
